// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: writeback, long-latency result, register-file and hazard-query signals of the write-port arbiter.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) ();
  logic                   pipe_we_i;
  logic [ADDR_W-1:0]      pipe_addr_i;
  logic [DATA_W-1:0]      pipe_data_i;
  logic                   lu_valid_i;
  logic [ADDR_W-1:0]      lu_addr_i;
  logic [DATA_W-1:0]      lu_data_i;
  logic                   lu_ready_o;
  logic                   stall_o;
  logic                   rf_we_o;
  logic [ADDR_W-1:0]      rf_addr_o;
  logic [DATA_W-1:0]      rf_data_o;
  logic                   rf_src_o;
  logic [ADDR_W-1:0]      q_addr_i;
  logic                   q_busy_o;
  logic [$clog2(DEPTH):0] count_o;
  modport master (
    output pipe_we_i, pipe_addr_i, pipe_data_i, lu_valid_i, lu_addr_i, lu_data_i, q_addr_i,
    input  lu_ready_o, stall_o, rf_we_o, rf_addr_o, rf_data_o, rf_src_o, q_busy_o, count_o
  );
  modport slave (
    input  pipe_we_i, pipe_addr_i, pipe_data_i, lu_valid_i, lu_addr_i, lu_data_i, q_addr_i,
    output lu_ready_o, stall_o, rf_we_o, rf_addr_o, rf_data_o, rf_src_o, q_busy_o, count_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline writeback and buffered long-latency results.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  wb_port_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(STARVE_MAX + 1);
  logic [ADDR_W-1:0] m_addr [DEPTH];
  logic [DATA_W-1:0] m_data [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [AW-1:0]     age;
  logic              head_live, head_dead, pipe_eff, store, pop_live, pop, busy;
  // A squashed head never needs the port, so it is discarded in any cycle.
  assign head_live      = vld[rd_ptr];
  assign head_dead      = (bus.count_o != '0) && !vld[rd_ptr];
  assign pipe_eff       = bus.pipe_we_i && (bus.pipe_addr_i != '0) && !bus.stall_o;
  assign bus.lu_ready_o = bus.count_o < CW'(DEPTH);
  assign store          = bus.lu_valid_i && bus.lu_ready_o && (bus.lu_addr_i != '0);
  assign pop_live       = head_live && (bus.stall_o || !pipe_eff);
  assign pop            = pop_live || head_dead;
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy = busy | (vld[i] && m_addr[i] == bus.q_addr_i);
  end
  assign bus.q_busy_o = busy && (bus.q_addr_i != '0);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.rf_we_o   <= 1'b0;
      bus.rf_addr_o <= '0;
      bus.rf_data_o <= '0;
      bus.rf_src_o  <= 1'b0;
      bus.stall_o   <= 1'b0;
      bus.count_o   <= '0;
      vld           <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      age           <= '0;
    end else begin
      bus.rf_we_o <= pop_live || pipe_eff;
      if (pop_live) begin
        bus.rf_addr_o <= m_addr[rd_ptr];
        bus.rf_data_o <= m_data[rd_ptr];
        bus.rf_src_o  <= 1'b1;
      end else if (pipe_eff) begin
        bus.rf_addr_o <= bus.pipe_addr_i;
        bus.rf_data_o <= bus.pipe_data_i;
        bus.rf_src_o  <= 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) if (pipe_eff && m_addr[i] == bus.pipe_addr_i) vld[i] <= 1'b0;
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PW'(1);
      end
      // The pushed entry is younger than a same-cycle pipe write, so it lands after the squash.
      if (store) begin
        vld[wr_ptr]    <= 1'b1;
        m_addr[wr_ptr] <= bus.lu_addr_i;
        m_data[wr_ptr] <= bus.lu_data_i;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      bus.count_o <= bus.count_o + CW'(store) - CW'(pop);
      age         <= (pop || !head_live) ? '0 : age + AW'(1);
      bus.stall_o <= head_live && !pop && age == AW'(STARVE_MAX - 1);
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and random stimulus checked against a queue-based model of the write-port arbiter.
module tb_wb_port_arbiter;
  localparam int DW = 32, AW = 5, DEPTH = 2, SM = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  wb_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) bus ();
  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d; bit live;} ent_t;
  ent_t fq[$];
  bit m_stall, e_we, e_src;
  int m_age;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  int vectors = 0, miscompares = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic bit m_busy(input logic [AW-1:0] qa);
    bit b = 0;
    foreach (fq[i]) if (fq[i].live && fq[i].a == qa) b = 1;
    return b && qa != 0;
  endfunction
  task automatic compare();
    chk("stall", 64'(bus.stall_o), 64'(m_stall));
    chk("count", 64'(bus.count_o), 64'(fq.size()));
    chk("lu_ready", 64'(bus.lu_ready_o), 64'(fq.size() < DEPTH));
    chk("rf_we", 64'(bus.rf_we_o), 64'(e_we));
    chk("q_busy", 64'(bus.q_busy_o), 64'(m_busy(bus.q_addr_i)));
    if (e_we) begin
      chk("rf_addr", 64'(bus.rf_addr_o), 64'(e_addr));
      chk("rf_data", 64'(bus.rf_data_o), 64'(e_data));
      chk("rf_src", 64'(bus.rf_src_o), 64'(e_src));
    end
  endtask
  task automatic model_step();
    bit hl, hd, pe, rdy, popl;
    if (rst) begin
      fq.delete();
      m_stall = 0; m_age = 0; e_we = 0; e_src = 0; e_addr = 0; e_data = 0;
      return;
    end
    hl   = fq.size() > 0 && fq[0].live;
    hd   = fq.size() > 0 && !fq[0].live;
    pe   = bus.pipe_we_i && bus.pipe_addr_i != 0 && !m_stall;
    rdy  = fq.size() < DEPTH;
    popl = hl && (m_stall || !pe);
    e_we = popl || pe;
    if (popl) begin
      e_addr = fq[0].a; e_data = fq[0].d; e_src = 1;
    end else if (pe) begin
      e_addr = bus.pipe_addr_i; e_data = bus.pipe_data_i; e_src = 0;
    end
    if (pe) foreach (fq[i]) if (fq[i].a == bus.pipe_addr_i) fq[i].live = 0;
    if (popl || hd) void'(fq.pop_front());
    m_stall = hl && !popl && m_age == SM - 1;
    m_age   = (popl || !hl) ? 0 : m_age + 1;
    if (bus.lu_valid_i && rdy && bus.lu_addr_i != 0) fq.push_back('{bus.lu_addr_i, bus.lu_data_i, 1'b1});
  endtask
  task automatic tick();
    #2;
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic pipe(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.pipe_we_i = we; bus.pipe_addr_i = a; bus.pipe_data_i = d;
  endtask
  task automatic lu(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.lu_valid_i = v; bus.lu_addr_i = a; bus.lu_data_i = d;
  endtask
  initial begin
    logic [AW-1:0] seq [4];
    int n;
    pipe(0, 0, 0); lu(0, 0, 0); bus.q_addr_i = 0;
    repeat (2) @(posedge clk);
    #1;
    model_step();
    rst = 0;
    chk("reset_count", 64'(bus.count_o), 64'd0);
    chk("reset_rf_we", 64'(bus.rf_we_o), 64'd0);
    chk("reset_stall", 64'(bus.stall_o), 64'd0);
    // reset with two entries buffered
    pipe(1, 3, 32'h1); lu(1, 10, 32'hA0); tick();
    lu(1, 11, 32'hB0); tick();
    lu(0, 0, 0);
    chk("buffered_count", 64'(bus.count_o), 64'd2);
    pipe(0, 0, 0); rst = 1; tick(); rst = 0;
    chk("rst_count", 64'(bus.count_o), 64'd0);
    chk("rst_rf_we", 64'(bus.rf_we_o), 64'd0);
    chk("rst_ready", 64'(bus.lu_ready_o), 64'd1);
    repeat (4) tick();
    // single LU result on an idle pipe
    lu(1, 7, 32'hDEADBEEF); tick(); lu(0, 0, 0);
    chk("lu_push_count", 64'(bus.count_o), 64'd1);
    tick();
    chk("lu_wr_we", 64'(bus.rf_we_o), 64'd1);
    chk("lu_wr_addr", 64'(bus.rf_addr_o), 64'd7);
    chk("lu_wr_data", 64'(bus.rf_data_o), 64'hDEADBEEF);
    chk("lu_wr_src", 64'(bus.rf_src_o), 64'd1);
    chk("lu_wr_count", 64'(bus.count_o), 64'd0);
    // starvation forces a one-cycle stall
    pipe(1, 3, 32'd100); lu(1, 9, 32'h99); tick(); lu(0, 0, 0);
    for (int k = 1; k <= SM; k++) begin
      pipe(1, 3, 32'(100 + k)); tick();
      chk("starve_pipe_src", 64'(bus.rf_src_o), 64'd0);
    end
    chk("starve_stall", 64'(bus.stall_o), 64'd1);
    pipe(1, 3, 32'd200); tick();
    chk("stall_wr_addr", 64'(bus.rf_addr_o), 64'd9);
    chk("stall_wr_src", 64'(bus.rf_src_o), 64'd1);
    chk("stall_drop", 64'(bus.stall_o), 64'd0);
    tick();
    chk("held_addr", 64'(bus.rf_addr_o), 64'd3);
    chk("held_data", 64'(bus.rf_data_o), 64'd200);
    chk("held_src", 64'(bus.rf_src_o), 64'd0);
    pipe(0, 0, 0); tick();
    // fill, backpressure and ordering across pointer wrap
    pipe(1, 3, 32'h5); lu(1, 20, 32'h20); tick();
    lu(1, 21, 32'h21); tick();
    lu(1, 22, 32'h22);
    chk("full_ready", 64'(bus.lu_ready_o), 64'd0);
    tick();
    pipe(0, 0, 0);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      bit acc;
      acc = bus.lu_valid_i && bus.lu_ready_o;
      tick();
      if (acc) lu(0, 0, 0);
      if (bus.rf_we_o && bus.rf_src_o && n < 4) begin
        seq[n] = bus.rf_addr_o;
        n++;
      end
    end
    chk("order_n", 64'(n), 64'd3);
    chk("order_0", 64'(seq[0]), 64'd20);
    chk("order_1", 64'(seq[1]), 64'd21);
    chk("order_2", 64'(seq[2]), 64'd22);
    // squash of a buffered entry by a younger pipe write
    pipe(1, 3, 32'h7); lu(1, 5, 32'h55); tick(); lu(0, 0, 0);
    pipe(1, 5, 32'h11); bus.q_addr_i = 5; #1;
    chk("squash_busy_before", 64'(bus.q_busy_o), 64'd1);
    tick();
    chk("squash_addr", 64'(bus.rf_addr_o), 64'd5);
    chk("squash_data", 64'(bus.rf_data_o), 64'h11);
    chk("squash_src", 64'(bus.rf_src_o), 64'd0);
    chk("squash_busy_after", 64'(bus.q_busy_o), 64'd0);
    pipe(0, 0, 0); tick();
    chk("squash_no_write", 64'(bus.rf_we_o), 64'd0);
    chk("squash_count", 64'(bus.count_o), 64'd0);
    // register zero is never written
    lu(1, 0, 32'hFF); tick(); lu(0, 0, 0);
    chk("lu_zero_count", 64'(bus.count_o), 64'd0);
    tick();
    chk("lu_zero_we", 64'(bus.rf_we_o), 64'd0);
    pipe(1, 0, 32'hEE); tick(); pipe(0, 0, 0);
    chk("pipe_zero_we", 64'(bus.rf_we_o), 64'd0);
    // random traffic with narrow addresses to provoke squashes and stalls
    for (int k = 0; k < 3000; k++) begin
      if (!bus.stall_o) pipe($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom);
      lu($urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)), $urandom);
      bus.q_addr_i = AW'($urandom_range(0, 7));
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
